// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame controller: state encoding, default widths, clog2.
package uart_alu_pkg;

    localparam int NB_DATA_DEF   = 8;
    localparam int N_BITS_OP_DEF = 6;

    localparam logic [2:0] RX_A    = 3'd0;
    localparam logic [2:0] RX_B    = 3'd1;
    localparam logic [2:0] RX_OP   = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] TX      = 3'd4;
    localparam logic [2:0] WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        S_RX_A    = RX_A,
        S_RX_B    = RX_B,
        S_RX_OP   = RX_OP,
        S_EXEC    = EXEC,
        S_TX      = TX,
        S_WAIT_TX = WAIT_TX
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_alu_frame_ctrl_if.sv
// Bundle of UART byte, ALU operand and status signals between the frame controller and its surroundings.
interface uart_alu_frame_ctrl_if #(
    parameter int NB_DATA    = 8,
    parameter int NB_OPERAND = 16,
    parameter int N_BITS_OP  = 6
);
    logic [NB_DATA-1:0]    i_rx_data;
    logic                  i_rx_done;
    logic                  i_tx_done;
    logic [NB_DATA-1:0]    o_tx_data;
    logic                  o_tx_start;
    logic [NB_OPERAND-1:0] o_alu_a;
    logic [NB_OPERAND-1:0] o_alu_b;
    logic [N_BITS_OP-1:0]  o_alu_op;
    logic [NB_OPERAND-1:0] i_alu_result;
    logic                  o_busy;
    logic                  o_err;
    logic                  o_overrun;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_tx_data, o_tx_start, o_alu_a, o_alu_b, o_alu_op, o_busy, o_err, o_overrun
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_tx_data, o_tx_start, o_alu_a, o_alu_b, o_alu_op, o_busy, o_err, o_overrun
    );
endinterface

// File: rtl/uart_alu_frame_ctrl_byte_deserializer.sv
// Little-endian byte assembler: NBYTES shifts build one word; o_done marks the shift of the last byte.
module byte_deserializer #(
    parameter int NB_DATA = 8,
    parameter int NBYTES  = 2,
    parameter int NB_CNT  = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_shift,
    input  logic [NB_DATA-1:0]        i_data,
    output logic [NB_DATA*NBYTES-1:0] o_word,
    output logic                      o_done,
    output logic                      o_any
);
    logic [NB_DATA*NBYTES-1:0] r_word;
    logic [NB_DATA*NBYTES-1:0] w_shifted;
    logic [NB_CNT-1:0]         r_cnt;
    logic                      w_last;

    // Shifting right leaves the first byte received in the low bits once the word is full.
    generate
        if (NBYTES == 1) begin : g_single
            assign w_shifted = i_data;
        end else begin : g_multi
            assign w_shifted = {i_data, r_word[NB_DATA*NBYTES-1:NB_DATA]};
        end
    endgenerate

    assign w_last = (r_cnt == NB_CNT'(NBYTES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= w_shifted;
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_word = r_word;
    assign o_done = i_shift && w_last;
    assign o_any  = (r_cnt != '0);

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Frames A/B/opcode bytes from uart_rx into the ALU and streams the result back through uart_tx.
// Opcode byte to first o_tx_start is two cycles; bytes arriving while busy are dropped and flagged.
module uart_alu_frame_ctrl
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int NB_OPERAND  = 16,
    parameter int N_BITS_OP   = N_BITS_OP_DEF,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    uart_alu_frame_ctrl_if.slave bus
);
    localparam int NBYTES = NB_OPERAND / NB_DATA;
    localparam int NB_CNT = clog2((NBYTES > 2) ? NBYTES : 2);
    localparam int NB_TMO = clog2(TIMEOUT_CYC + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NB_CNT-1:0]     r_k;
    logic [NB_CNT-1:0]     w_k_nxt;
    logic [NB_TMO-1:0]     r_tmo;
    logic [NB_OPERAND-1:0] r_result;
    logic [NB_OPERAND-1:0] r_alu_a;
    logic [NB_OPERAND-1:0] r_alu_b;
    logic [N_BITS_OP-1:0]  r_alu_op;
    logic [NB_DATA-1:0]    r_tx_data;
    logic                  r_err;
    logic                  r_overrun;

    logic [NB_OPERAND-1:0] w_word_a;
    logic [NB_OPERAND-1:0] w_word_b;
    logic                  w_done_a;
    logic                  w_done_b;
    logic                  w_any_a;
    logic                  w_any_b;
    logic                  w_shift_a;
    logic                  w_shift_b;
    logic                  w_clear_asm;
    logic                  w_load_alu;
    logic                  w_busy;
    logic                  w_rx_state;
    logic                  w_partial;
    logic                  w_tmo_hit;
    logic                  w_k_last;
    logic                  w_unused_rx;

    logic [NBYTES-1:0][NB_DATA-1:0] w_tx_bytes;
    logic [NB_DATA-1:0]             w_tx_byte;

    byte_deserializer #(.NB_DATA(NB_DATA), .NBYTES(NBYTES), .NB_CNT(NB_CNT)) u_deser_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(w_clear_asm), .i_shift(w_shift_a),
        .i_data(bus.i_rx_data), .o_word(w_word_a), .o_done(w_done_a), .o_any(w_any_a)
    );

    byte_deserializer #(.NB_DATA(NB_DATA), .NBYTES(NBYTES), .NB_CNT(NB_CNT)) u_deser_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(w_clear_asm), .i_shift(w_shift_b),
        .i_data(bus.i_rx_data), .o_word(w_word_b), .o_done(w_done_b), .o_any(w_any_b)
    );

    assign w_busy     = (r_state == S_EXEC) || (r_state == S_TX) || (r_state == S_WAIT_TX);
    assign w_rx_state = !w_busy;
    // Any byte of A already in, or any state past RX_A, means a frame is in flight.
    assign w_partial  = w_rx_state && (w_any_a || w_any_b || (r_state != S_RX_A));
    assign w_tmo_hit  = w_partial && (r_tmo == NB_TMO'(TIMEOUT_CYC - 1));
    assign w_k_last   = (r_k == NB_CNT'(NBYTES - 1));
    assign w_unused_rx = &{1'b0, bus.i_rx_data};

    always_comb begin
        w_state_nxt = r_state;
        w_shift_a   = 1'b0;
        w_shift_b   = 1'b0;
        w_load_alu  = 1'b0;
        w_clear_asm = 1'b0;
        w_k_nxt     = r_k;
        case (r_state)
            S_RX_A: begin
                if (bus.i_rx_done) begin
                    w_shift_a = 1'b1;
                    if (w_done_a) w_state_nxt = S_RX_B;
                end else if (w_tmo_hit) begin
                    w_clear_asm = 1'b1;
                    w_state_nxt = S_RX_A;
                end
            end
            S_RX_B: begin
                if (bus.i_rx_done) begin
                    w_shift_b = 1'b1;
                    if (w_done_b) w_state_nxt = S_RX_OP;
                end else if (w_tmo_hit) begin
                    w_clear_asm = 1'b1;
                    w_state_nxt = S_RX_A;
                end
            end
            S_RX_OP: begin
                if (bus.i_rx_done) begin
                    w_load_alu  = 1'b1;
                    w_state_nxt = S_EXEC;
                end else if (w_tmo_hit) begin
                    w_clear_asm = 1'b1;
                    w_state_nxt = S_RX_A;
                end
            end
            S_EXEC:  w_state_nxt = S_TX;
            S_TX:    w_state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    w_k_nxt     = w_k_last ? '0 : r_k + 1'b1;
                    w_state_nxt = w_k_last ? S_RX_A : S_TX;
                end
            end
            default: w_state_nxt = S_RX_A;
        endcase
    end

    // The first byte comes straight from the ALU because r_result loads on the same edge.
    assign w_tx_bytes = (r_state == S_EXEC) ? bus.i_alu_result : r_result;
    generate
        if (NBYTES == 1) begin : g_tx_single
            assign w_tx_byte = w_tx_bytes[0];
        end else begin : g_tx_multi
            assign w_tx_byte = w_tx_bytes[w_k_nxt];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= S_RX_A;
            r_k       <= '0;
            r_tmo     <= '0;
            r_result  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_err     <= w_clear_asm;
            r_overrun <= bus.i_rx_done && w_busy;
            if ((w_rx_state && bus.i_rx_done) || w_clear_asm) begin
                r_tmo <= '0;
            end else if (w_partial) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_load_alu) begin
                r_alu_a  <= w_word_a;
                r_alu_b  <= w_word_b;
                r_alu_op <= bus.i_rx_data[N_BITS_OP-1:0];
            end
            if (r_state == S_EXEC) r_result <= bus.i_alu_result;
            if (w_state_nxt == S_TX) r_tx_data <= w_tx_byte;
        end
    end

    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = (r_state == S_TX);
    assign bus.o_alu_a    = r_alu_a;
    assign bus.o_alu_b    = r_alu_b;
    assign bus.o_alu_op   = r_alu_op;
    assign bus.o_busy     = w_busy;
    assign bus.o_err      = r_err;
    assign bus.o_overrun  = r_overrun;

endmodule

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
- Parametrised command/response controller between the UART receiver/transmitter and the ALU in the calculator top level.
- Assembles a frame of operand A, operand B and opcode from received UART bytes. Operands are NB_OPERAND wide and may span several bytes.
- Drives the ALU, then streams the multi-byte result back through uart_tx.
- Generalises the fixed 8-bit A/B/OP interface with inter-byte timeout, overrun detection and an error pulse.

Parameters:
- NB_DATA, 8, UART byte width.
- NB_OPERAND, 16, ALU operand/result width; must be an integer multiple of NB_DATA.
- N_BITS_OP, 6, ALU opcode width; must be <= NB_DATA.
- TIMEOUT_CYC, 100000, idle clock cycles allowed between bytes of a partial frame.
- Derived: NBYTES = NB_OPERAND/NB_DATA; NB_CNT = clog2(max(NBYTES,2)); NB_TMO = clog2(TIMEOUT_CYC+1).

Ports:
- i_clk  in  1  single system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset), sampled on the i_clk rising edge.
- i_rx_data  in  NB_DATA  byte from uart_rx.
- i_rx_done  in  1  one-cycle pulse, i_rx_data valid.
- i_tx_done  in  1  one-cycle pulse from uart_tx, current byte sent.
- o_tx_data  out  NB_DATA  byte to uart_tx; held stable until the matching i_tx_done.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_alu_a  out  NB_OPERAND  operand A of the last completed frame.
- o_alu_b  out  NB_OPERAND  operand B of the last completed frame.
- o_alu_op  out  N_BITS_OP  opcode of the last completed frame.
- i_alu_result  in  NB_OPERAND  combinational ALU result.
- o_busy  out  1  high in EXEC, TX and WAIT_TX.
- o_err  out  1  one-cycle pulse on inter-byte timeout.
- o_overrun  out  1  one-cycle pulse when i_rx_done arrives while busy.

Behaviour:
- Reset: every output, shift register, counter and result register clears to 0; state = RX_A.
- Reset mid-operation aborts any frame or transmission; no o_tx_start may follow.
- Byte order is little-endian: the first received byte goes to bits [NB_DATA-1:0]. The same order applies to transmit.
- The opcode byte uses bits [N_BITS_OP-1:0]; upper bits are ignored.
- States: RX_A, RX_B, RX_OP, EXEC, TX, WAIT_TX.
- RX_A/RX_B: each i_rx_done shifts the byte into an internal assembly register and increments the byte counter.
  - After NBYTES bytes: counter clears; RX_A goes to RX_B, RX_B goes to RX_OP.
- RX_OP: on i_rx_done, o_alu_a, o_alu_b and o_alu_op load together from the assembly registers at that edge, then state goes to EXEC.
  - The ALU never sees a partial frame.
- EXEC: lasts one cycle; i_alu_result is captured into the result register; state goes to TX.
- TX: o_tx_start = 1 for exactly one cycle, o_tx_data = result byte[k]; state goes to WAIT_TX.
- WAIT_TX: on i_tx_done, k increments.
  - If k was NBYTES-1: k clears and state goes to RX_A.
  - Otherwise: state goes back to TX.
- Latency: i_rx_done for the opcode at edge t gives o_alu_* valid after t, the result captured at t+1, and o_tx_start high in cycle t+2.
- Timeout:
  - The counter runs only when the frame is partial (any byte received and state is RX_A/B/OP).
  - It clears on every i_rx_done.
  - On reaching TIMEOUT_CYC-1 without i_rx_done: o_err pulses the next cycle, assembly state and counters clear, state goes to RX_A.
  - o_alu_* keep the previous frame's values.
- Simultaneous timeout expiry and i_rx_done in the same cycle: the byte is accepted and no error is raised.
- i_rx_done while o_busy = 1: the byte is dropped, o_overrun pulses for one cycle, and the TX sequence is unaffected.
- i_tx_done outside WAIT_TX is ignored.
- o_tx_data holds the last value between transmissions.

Decomposition:
- Shared package uart_alu_pkg:
  - state encoding localparams: RX_A=0, RX_B=1, RX_OP=2, EXEC=3, TX=4, WAIT_TX=5;
  - default NB_DATA, N_BITS_OP;
  - clog2 function.
- One natural sub-module: byte_deserializer, parametrised by NB_DATA/NBYTES. It is the shift register plus byte counter with a done flag, instantiated for A and B.
- The result serializer stays inline (mux on k).

Test Plan:
1. NB_OPERAND=16, ALU model = A+B when op=0x20. Send bytes 34 12 01 00 20 → o_alu_a=0x1234, o_alu_b=0x0001, o_alu_op=0x20, o_tx_start 2 cycles after the last i_rx_done, transmitted bytes 35 then 12, then o_busy=0.
2. Timeout: send 34 12, wait TIMEOUT_CYC idle cycles → o_err single pulse, o_alu_* unchanged. A following full frame 0A 00 05 00 20 transmits 0F 00.
3. Overrun: inject i_rx_done=AB during WAIT_TX → o_overrun single pulse; result bytes unchanged; next frame decodes correctly with no leftover byte.
4. Opcode masking: N_BITS_OP=6, opcode byte E2 → o_alu_op=0x22.
5. Reset mid-TX: drive i_reset=0 for one cycle after the first i_tx_done → all outputs 0, no further o_tx_start. A new frame completes normally.
6. NB_OPERAND=8 back-to-back frames 0A 0A 20 then 64 0A 20 → transmitted 14 then 6E, no o_err, no o_overrun.
